// File: rtl/rate_pkg.sv
// rtl/rate_pkg.sv - shared types and defaults for the rate sequencer
// Contents: state_e (IDLE/RAMP_UP/RAMP_DN), level_t (3-bit level), LEVEL_MAX_DEFAULT.
package rate_pkg;

  localparam int LEVEL_MAX_DEFAULT = 5;

  typedef logic [2:0] level_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    RAMP_DN = 2'd2
  } state_e;

endpackage

// File: rtl/rate_divider.sv
// rtl/rate_divider.sv - programmable tick divider, period DIV_BASE << (LEVEL_MAX - level)
// Ports: clk, reset (sync, active-high), level (0 = stopped),
//        tick (one-cycle pulse per period), square (toggles on each tick, 0 when stopped).
module rate_divider
  import rate_pkg::*;
#(
  parameter int LEVEL_MAX = LEVEL_MAX_DEFAULT,
  parameter int DIV_BASE  = 1562500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] level,
  output logic       tick,
  output logic       square
);

  localparam int CW_RAW = $clog2(DIV_BASE << (LEVEL_MAX - 1));
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_m1;
  logic [31:0]   period;
  logic [2:0]    lvl_q;
  logic          sq_q, sq_d;
  logic          lvl_chg;

  always_comb begin
    period    = 32'(DIV_BASE) << (LEVEL_MAX - int'(level));
    period_m1 = CW'(period - 32'd1);
    // A level change restarts the period; the stale count must not produce a tick.
    lvl_chg   = (level != lvl_q);
    tick      = (level != 3'd0) && !lvl_chg && (cnt_q == period_m1);
    cnt_d     = cnt_q + 1'b1;
    sq_d      = sq_q;
    if (level == 3'd0) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (lvl_chg || tick) begin
      cnt_d = '0;
      sq_d  = sq_q ^ tick;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      lvl_q <= 3'd0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= level;
      sq_q  <= sq_d;
    end
  end

  assign square = sq_q;

endmodule

// File: rtl/rate_sequencer.sv
// rtl/rate_sequencer.sv - button-driven rate level target with dwell-timed ramp and tick divider
// Ports: CLK_50, reset (sync, active-high), up_req/dn_req (debounced button levels),
//        target_lvl, cur_lvl, slow_tick, slow_clk, busy, at_limit.
module rate_sequencer
  import rate_pkg::*;
#(
  parameter int LEVEL_MAX    = LEVEL_MAX_DEFAULT,
  parameter int DIV_BASE     = 1562500,
  parameter int DWELL_CYCLES = 12500000
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       up_req,
  input  logic       dn_req,
  output logic [2:0] target_lvl,
  output logic [2:0] cur_lvl,
  output logic       slow_tick,
  output logic       slow_clk,
  output logic       busy,
  output logic       at_limit
);

  localparam int DW_RAW = $clog2(DWELL_CYCLES);
  localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam level_t LMAX = level_t'(LEVEL_MAX);

  logic          up_hist_q, dn_hist_q;
  logic          up_det, dn_det;
  level_t        target_q, target_d;
  level_t        cur_q, cur_d;
  state_e        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          busy_q, busy_d;
  logic          at_limit_q, at_limit_d;

  always_comb begin
    // Rising edge only, so a held button counts once.
    up_det   = up_req & ~up_hist_q;
    dn_det   = dn_req & ~dn_hist_q;

    target_d = target_q;
    if (up_det && !dn_det && (target_q < LMAX)) begin
      target_d = target_q + 3'd1;
    end else if (dn_det && !up_det && (target_q != 3'd0)) begin
      target_d = target_q - 3'd1;
    end

    state_d = state_q;
    cur_d   = cur_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (target_q > cur_q) begin
          state_d = RAMP_UP;
          dwell_d = '0;
        end else if (target_q < cur_q) begin
          state_d = RAMP_DN;
          dwell_d = '0;
        end
      end
      RAMP_UP: begin
        if (cur_q == target_q) begin
          state_d = IDLE;
        end else if (target_q < cur_q) begin
          state_d = RAMP_DN;
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          cur_d   = cur_q + 3'd1;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      RAMP_DN: begin
        if (cur_q == target_q) begin
          state_d = IDLE;
        end else if (target_q > cur_q) begin
          state_d = RAMP_UP;
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          cur_d   = cur_q - 3'd1;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        dwell_d = '0;
      end
    endcase

    // Derived from next-state values so the flops track state/target with no extra lag.
    busy_d     = (state_d != IDLE);
    at_limit_d = (target_d == 3'd0) || (target_d == LMAX);
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      up_hist_q  <= 1'b0;
      dn_hist_q  <= 1'b0;
      target_q   <= 3'd0;
      cur_q      <= 3'd0;
      state_q    <= IDLE;
      dwell_q    <= '0;
      busy_q     <= 1'b0;
      at_limit_q <= 1'b1;
    end else begin
      up_hist_q  <= up_req;
      dn_hist_q  <= dn_req;
      target_q   <= target_d;
      cur_q      <= cur_d;
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      busy_q     <= busy_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign target_lvl = target_q;
  assign cur_lvl    = cur_q;
  assign busy       = busy_q;
  assign at_limit   = at_limit_q;

  rate_divider #(
    .LEVEL_MAX (LEVEL_MAX),
    .DIV_BASE  (DIV_BASE)
  ) u_div (
    .clk    (CLK_50),
    .reset  (reset),
    .level  (cur_q),
    .tick   (slow_tick),
    .square (slow_clk)
  );

endmodule

// File: doc/rate_sequencer.md
RATE_SEQUENCER -- requirements
Module: rate_sequencer

Interface
REQ-001 SHALL have parameter LEVEL_MAX, default 5: highest rate level; level 0 means stopped.
REQ-002 SHALL have parameter DIV_BASE, default 1562500: tick period at LEVEL_MAX, in clock cycles.
REQ-003 SHALL have parameter DWELL_CYCLES, default 12500000: clock cycles spent at each level during a ramp.
REQ-004 SHALL have port CLK_50, input, 1 bit: the single system clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port up_req, input, 1 bit: debounced rate-up button level.
REQ-007 SHALL have port dn_req, input, 1 bit: debounced rate-down button level.
REQ-008 SHALL have port target_lvl, output, 3 bits: requested level.
REQ-009 SHALL have port cur_lvl, output, 3 bits: level currently driving the divider.
REQ-010 SHALL have port slow_tick, output, 1 bit: one-cycle pulse at the current rate.
REQ-011 SHALL have port slow_clk, output, 1 bit: square wave that toggles on each slow_tick.
REQ-012 SHALL have port busy, output, 1 bit: high while a ramp is in progress.
REQ-013 SHALL have port at_limit, output, 1 bit: high when target_lvl equals 0 or LEVEL_MAX.

Function
REQ-014 SHALL register up_req and dn_req and detect a request as: current sample 1 and previous sample 0.
REQ-015 SHALL increment target_lvl on the same edge that an up request is detected; saturate at LEVEL_MAX.
REQ-016 SHALL decrement target_lvl on the same edge that a down request is detected; saturate at 0.
REQ-017 SHALL ignore up and down requests detected on the same edge; target_lvl is unchanged.
REQ-018 SHALL count a held button as exactly one request, regardless of hold time.
REQ-019 SHALL implement an FSM with states IDLE, RAMP_UP and RAMP_DN.
REQ-020 In IDLE, SHALL go to RAMP_UP if target_lvl > cur_lvl, go to RAMP_DN if target_lvl < cur_lvl, else stay; the dwell counter clears on entry to either ramp state.
REQ-021 In a ramp state, the dwell counter SHALL increment each cycle; at DWELL_CYCLES-1 it SHALL step cur_lvl by ±1 toward target_lvl and clear.
REQ-022 In a ramp state, SHALL return to IDLE on the edge after cur_lvl equals target_lvl.
REQ-023 If target_lvl crosses cur_lvl mid-ramp (direction reverses), SHALL switch to the opposite ramp state on the next edge and clear the dwell counter.
REQ-024 If target_lvl changes mid-ramp without a reversal, SHALL continue the ramp with the dwell counter running.
REQ-025 busy SHALL equal (state != IDLE), registered.
REQ-026 Divider period for level n ≥ 1 SHALL be P(n) = DIV_BASE << (LEVEL_MAX − n) cycles.
REQ-027 The divider counter SHALL count 0..P(n)−1; slow_tick SHALL assert for one cycle when the count equals P(n)−1.
REQ-028 The divider counter SHALL clear on every change of cur_lvl; no partial-period tick is emitted.
REQ-029 At level 0, the divider counter SHALL hold at 0, slow_tick SHALL be 0, and slow_clk SHALL be forced to 0.
REQ-030 The divider counter width SHALL be $clog2(DIV_BASE << (LEVEL_MAX−1)); with defaults this is 25 bits.
REQ-031 The dwell counter width SHALL be $clog2(DWELL_CYCLES).

Reset
REQ-032 On reset, the following SHALL take these values: target_lvl=0, cur_lvl=0, state=IDLE, both counters=0, input history registers=0, slow_tick=0, slow_clk=0, busy=0, at_limit=1.
REQ-033 Reset asserted mid-ramp SHALL abort the ramp, with all outputs at reset values on the following cycle.

Structure
REQ-034 Package rate_pkg SHALL hold the state enum (IDLE/RAMP_UP/RAMP_DN), the LEVEL_MAX default and the 3-bit level typedef.
REQ-035 The divider SHALL be a sub-module rate_divider (inputs: level, clock, reset; outputs: tick, square).
REQ-036 Edge detection and the FSM SHALL be inline in rate_sequencer.

Verification (DIV_BASE=2, DWELL_CYCLES=8, LEVEL_MAX=5)
REQ-037 Reset, then 3 separate up presses -> target_lvl=3; cur_lvl steps 1, 2, 3 at 8-cycle intervals; busy high throughout, then low; slow_tick every 8 cycles at level 3.
REQ-038 7 up presses -> target_lvl=5, at_limit=1, slow_tick every 2 cycles; then 6 down presses -> target_lvl=0, cur_lvl ramps to 0, slow_clk=0.
REQ-039 up_req and dn_req rise on the same cycle -> target_lvl, state and busy unchanged.
REQ-040 up_req held high for 100 cycles -> target_lvl increments exactly once.
REQ-041 Target 4 from 0; at cur_lvl=2, 3 down presses -> target_lvl=1; state goes to RAMP_DN next cycle; cur_lvl=1 after 8 cycles; then IDLE.
REQ-042 reset pulsed at cur_lvl=3 mid-ramp -> next cycle all outputs at reset values and at_limit=1.
